// File: rtl/scandoubler.sv
// Line-doubling scan converter: captures each 15 kHz RGB222 line into a ping-pong
// buffer at the ck7 rate and replays the previous line twice at the ck14 rate.
module scandoubler #(
    parameter int ADDR_W        = 9,
    parameter int HSYNC_OUT_LEN = 54
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ck7,
    input  logic       ck14,
    input  logic [1:0] r_in,
    input  logic [1:0] g_in,
    input  logic [1:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hsync,
    output logic       vsync
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   HS_LEN   = (ADDR_W + 1)'(HSYNC_OUT_LEN);

    logic [5:0]        r_mem [0:2*DEPTH-1];
    logic [5:0]        r_rd_data;
    logic              r_hsync_in_d;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_wr_cnt;
    logic [ADDR_W:0]   r_line_len;
    logic              r_len_valid;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_vld1;
    logic              r_hs_raw;
    logic [5:0]        r_byp_rgb;
    logic              r_byp_hs;
    logic              r_vs1;

    logic              w_lse;
    logic              w_rd_last;
    logic [5:0]        w_wr_word;

    assign w_lse     = r_hsync_in_d & ~hsync_in;
    assign w_rd_last = ({1'b0, r_rd_addr} == (r_line_len - CNT_ONE));
    assign w_wr_word = {g_in, r_in, b_in};

    // Ping-pong line buffer: write into wr_bank, read the other bank one cycle later.
    always_ff @(posedge clk28) begin
        if (rst_n && ck7 && !w_lse) begin
            r_mem[{r_wr_bank, r_wr_addr}] <= w_wr_word;
        end
        r_rd_data <= r_mem[{~r_wr_bank, r_rd_addr}];
    end

    // Write side: line start swaps banks and latches the captured length.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            r_hsync_in_d <= 1'b1;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_cnt     <= '0;
            r_line_len   <= '0;
            r_len_valid  <= 1'b0;
        end else begin
            r_hsync_in_d <= hsync_in;
            if (w_lse) begin
                r_wr_bank   <= ~r_wr_bank;
                r_wr_addr   <= '0;
                r_wr_cnt    <= '0;
                r_line_len  <= r_wr_cnt;
                r_len_valid <= (r_wr_cnt != '0);
            end else if (ck7) begin
                // Over-long lines keep overwriting the last word; the count stops at DEPTH.
                if (r_wr_addr != ADDR_MAX) begin
                    r_wr_addr <= r_wr_addr + ADDR_ONE;
                end
                if (r_wr_cnt != CNT_MAX) begin
                    r_wr_cnt <= r_wr_cnt + CNT_ONE;
                end
            end
        end
    end

    // Read side: replays the stored line at ck14, wrapping to start the second copy.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
        end else if (w_lse) begin
            r_rd_addr <= '0;
        end else if (ck14 && r_len_valid) begin
            r_rd_addr <= w_rd_last ? '0 : (r_rd_addr + ADDR_ONE);
        end
    end

    // Two-stage output pipeline shared by the doubled path, the bypass path and vsync.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            r_vld1    <= 1'b0;
            r_hs_raw  <= 1'b1;
            r_byp_rgb <= 6'd0;
            r_byp_hs  <= 1'b1;
            r_vs1     <= 1'b1;
            r         <= 2'd0;
            g         <= 2'd0;
            b         <= 2'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            r_vld1    <= r_len_valid;
            r_hs_raw  <= !(r_len_valid && ({1'b0, r_rd_addr} < HS_LEN));
            r_byp_rgb <= {g_in, r_in, b_in};
            r_byp_hs  <= hsync_in;
            r_vs1     <= vsync_in;
            vsync     <= r_vs1;
            if (en) begin
                {g, r, b} <= r_vld1 ? r_rd_data : 6'd0;
                hsync     <= r_hs_raw;
            end else begin
                {g, r, b} <= r_byp_rgb;
                hsync     <= r_byp_hs;
            end
        end
    end

endmodule

// File: tb/tb_scandoubler.sv
// Randomised bench for scandoubler: a line-level reference model predicts every
// output cycle into a queue that an independent monitor drains and compares.
module tb_scandoubler;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HS_LEN = 54;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       ck7 = 1'b0;
    logic       ck14 = 1'b0;
    logic [1:0] r_in = 2'd0;
    logic [1:0] g_in = 2'd0;
    logic [1:0] b_in = 2'd0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hsync;
    logic       vsync;

    scandoubler #(.ADDR_W(ADDR_W), .HSYNC_OUT_LEN(HS_LEN)) dut (
        .clk28(clk28), .rst_n(rst_n), .en(en), .ck7(ck7), .ck14(ck14),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk28 = ~clk28;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // measurement window for hsync period / width
    bit   meas = 1'b0;
    int   meas_period = 896;
    int   meas_width  = 108;

    // reference model: pixels captured so far this line, and the line being replayed
    int   cur[$];
    int   stored[$];
    int   line_len = 0;
    bit   line_ok = 1'b0;
    int   n14 = 0;
    bit   hs_prev = 1'b1;
    logic [5:0] sd_pix_s1 = 6'd0;
    bit   sd_hs_s1  = 1'b1;
    logic [5:0] byp_s1 = 6'd0;
    bit   byp_hs_s1 = 1'b1;
    bit   vs_s1     = 1'b1;

    function automatic int pix_at(input int a);
        if (a == DEPTH - 1 && stored.size() > DEPTH) return stored[stored.size() - 1];
        return stored[a];
    endfunction

    task automatic model_edge();
        out_t e;
        int   a;
        bit   lse;
        e = '0;
        if (!rst_n) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            if (en) begin
                {e.g, e.r, e.b} = sd_pix_s1;
                e.hs = sd_hs_s1;
            end else begin
                {e.g, e.r, e.b} = byp_s1;
                e.hs = byp_hs_s1;
            end
            e.vs = vs_s1;
        end
        exp_q.push_back(e);

        if (!rst_n) begin
            sd_pix_s1 = 6'd0; sd_hs_s1 = 1'b1;
            byp_s1 = 6'd0; byp_hs_s1 = 1'b1; vs_s1 = 1'b1;
            cur.delete();
            line_ok = 1'b0; n14 = 0; hs_prev = 1'b1;
        end else begin
            if (line_ok) begin
                a = n14 % line_len;
                sd_pix_s1 = 6'(pix_at(a));
                sd_hs_s1  = !(a < HS_LEN);
            end else begin
                sd_pix_s1 = 6'd0;
                sd_hs_s1  = 1'b1;
            end
            byp_s1 = {g_in, r_in, b_in};
            byp_hs_s1 = hsync_in;
            vs_s1 = vsync_in;

            lse = hs_prev && !hsync_in;
            if (lse) begin
                stored = cur;
                cur.delete();
                line_len = (stored.size() > DEPTH) ? DEPTH : stored.size();
                line_ok = (line_len != 0);
                n14 = 0;
            end else begin
                if (ck7) cur.push_back(int'({g_in, r_in, b_in}));
                if (ck14 && line_ok) n14++;
            end
            hs_prev = hsync_in;
        end
    endtask

    task automatic tick();
        @(posedge clk28);
        model_edge();
        #1;
    endtask

    task automatic check_reset_outputs();
        n_checks++;
        if ({r, g, b} !== 6'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_out: got rgb=%h hs=%b vs=%b, want rgb=00 hs=1 vs=1",
                     {r, g, b}, hsync, vsync);
        end
    endtask

    // mode 0: pixel i carries i mod 64; mode 1: random colour
    task automatic run_line(input int nclk, input int ph, input int mode, input int rst_at);
        int pix;
        pix = 0;
        for (int t = 0; t < nclk; t++) begin
            hsync_in = (t >= 132);
            ck14 = (t % 2 == 0);
            ck7  = (t % 4 == ph);
            vsync_in = ($urandom_range(0, 63) != 0);
            if (mode == 0) {g_in, r_in, b_in} = 6'(pix % 64);
            else           {g_in, r_in, b_in} = 6'($urandom);
            if (ck7) pix++;
            rst_n = (t != rst_at);
            tick();
            if (t == rst_at) check_reset_outputs();
        end
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int ncyc);
        for (int t = 0; t < ncyc; t++) begin
            ck14 = (t % 2 == 0);
            ck7  = (t % 4 == 1);
            {g_in, r_in, b_in} = 6'($urandom);
            if ($urandom_range(0, 39) == 0) hsync_in = ~hsync_in;
            vsync_in = ($urandom_range(0, 7) != 0);
            tick();
        end
    endtask

    // monitor: one scoreboard comparison per cycle plus hsync timing in the window
    initial begin
        out_t e;
        out_t got;
        int   mcyc;
        int   last_fall;
        bit   prev_hs;
        mcyc = 0; last_fall = -1; prev_hs = 1'b1;
        forever begin
            @(negedge clk28);
            mcyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {r, g, b, hsync, vsync};
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL out @%0d: got r=%0d g=%0d b=%0d hs=%b vs=%b, want r=%0d g=%0d b=%0d hs=%b vs=%b",
                             mcyc, got.r, got.g, got.b, got.hs, got.vs, e.r, e.g, e.b, e.hs, e.vs);
                end
            end
            if (meas) begin
                if (prev_hs && !hsync) begin
                    if (last_fall >= 0) begin
                        n_checks++;
                        if (mcyc - last_fall != meas_period) begin
                            n_fail++;
                            $display("FAIL hs_period: got %0d want %0d", mcyc - last_fall, meas_period);
                        end
                    end
                    last_fall = mcyc;
                end
                if (!prev_hs && hsync && last_fall >= 0) begin
                    n_checks++;
                    if (mcyc - last_fall != meas_width) begin
                        n_fail++;
                        $display("FAIL hs_width: got %0d want %0d", mcyc - last_fall, meas_width);
                    end
                end
            end else begin
                last_fall = -1;
            end
            prev_hs = hsync;
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;

        run_line(1792, 1, 0, -1);
        meas_period = 896;
        meas = 1'b1;
        run_line(1792, 1, 1, -1);
        run_line(1792, 1, 1, -1);
        meas = 1'b0;

        run_line(2400, 1, 0, -1);
        meas_period = 1024;
        meas = 1'b1;
        run_line(1792, 0, 1, -1);
        meas = 1'b0;
        run_line(1792, 1, 1, -1);

        en = 1'b0;
        run_random(1500);
        en = 1'b1;
        run_random(800);
        hsync_in = 1'b1;

        run_line(1792, 1, 1, -1);
        run_line(1792, 1, 1, 1000);
        run_line(1792, 1, 0, -1);
        run_line(1792, 1, 1, -1);

        repeat (3) @(negedge clk28);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
